// File: rtl/rv32i_pkg.sv
// Shared types for the register-file writeback arbiter: request record,
// the hard-wired zero register and the arbiter state encoding.
package rv32i_pkg;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  typedef enum logic {ARB_NORMAL, ARB_FORCE} arb_state_t;

endpackage

// File: rtl/rv32i_wb_arbiter_if.sv
// Bus bundle between the writeback stage, the multicycle unit and the
// register-file write port; the arbiter takes the slave side.
interface rv32i_wb_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              pipe_wb_en;
  logic [4:0]        pipe_wb_reg;
  logic [31:0]       pipe_wb_data;
  logic              mc_valid;
  logic [4:0]        mc_reg;
  logic [31:0]       mc_data;
  logic              mc_ready;
  logic              pipe_stall;
  logic              wb_en_out;
  logic [4:0]        wb_reg_out;
  logic [31:0]       wb_data;
  logic [CNT_W-1:0]  pend_count;

  modport master (
    output pipe_wb_en, pipe_wb_reg, pipe_wb_data, mc_valid, mc_reg, mc_data,
    input  mc_ready, pipe_stall, wb_en_out, wb_reg_out, wb_data, pend_count
  );

  modport slave (
    input  pipe_wb_en, pipe_wb_reg, pipe_wb_data, mc_valid, mc_reg, mc_data,
    output mc_ready, pipe_stall, wb_en_out, wb_reg_out, wb_data, pend_count
  );

endinterface

// File: rtl/rv32i_wb_fifo.sv
// Pending multicycle-result FIFO; exposes per-slot rd and occupancy so the
// arbiter can detect same-register ordering hazards against every entry.
module rv32i_wb_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  wb_req_t                      push_req,
  input  logic                         pop,
  output wb_req_t                      head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [DEPTH-1:0][4:0]        entry_rd,
  output logic [DEPTH-1:0]             entry_vld
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PTR_W-1:0] ofs;
    assign ofs          = PTR_W'(i) - rd_ptr;
    assign entry_vld[i] = (CNT_W'(ofs) < count);
    assign entry_rd[i]  = mem[i].rd;
  end

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, multicycle
// results are queued and drained in idle cycles, on hazards or on starvation.
module rv32i_wb_arbiter
  import rv32i_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               reset,
  rv32i_wb_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t              state, state_nxt;
  logic [SW-1:0]           starve_cnt, cnt_nxt, cnt_inc;
  wb_req_t                 head, win_req;
  logic                    win_en;
  logic                    push, pop, bypass, stall;
  logic                    full, empty;
  logic [DEPTH-1:0][4:0]   entry_rd;
  logic [DEPTH-1:0]        entry_vld;
  logic                    pipe_req, hazard;

  rv32i_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_req  ({bus.mc_reg, bus.mc_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (bus.pend_count),
    .entry_rd  (entry_rd),
    .entry_vld (entry_vld)
  );

  assign pipe_req     = bus.pipe_wb_en && (bus.pipe_wb_reg != REG_X0);
  assign cnt_inc      = starve_cnt + SW'(1);
  assign bus.mc_ready = !full;
  assign bus.pipe_stall = stall;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && (entry_rd[i] == bus.pipe_wb_reg)) hazard = 1'b1;
    end
    hazard = hazard && pipe_req;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = starve_cnt;
    pop       = 1'b0;
    bypass    = 1'b0;
    stall     = 1'b0;
    win_en    = 1'b0;
    win_req   = '0;
    case (state)
      ARB_NORMAL: begin
        if (hazard) begin
          // Queued result is older than the stalled instruction: retire it first.
          stall   = 1'b1;
          pop     = 1'b1;
          win_en  = 1'b1;
          win_req = head;
          cnt_nxt = '0;
        end else if (pipe_req) begin
          win_en  = 1'b1;
          win_req = {bus.pipe_wb_reg, bus.pipe_wb_data};
          if (!empty) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == SW'(STARVE_MAX)) state_nxt = ARB_FORCE;
          end
        end else if (!empty) begin
          pop     = 1'b1;
          win_en  = 1'b1;
          win_req = head;
          cnt_nxt = '0;
        end else if (bus.mc_valid && (bus.mc_reg != REG_X0)) begin
          bypass  = 1'b1;
          win_en  = 1'b1;
          win_req = {bus.mc_reg, bus.mc_data};
        end
      end
      ARB_FORCE: begin
        stall     = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ARB_NORMAL;
        if (!empty) begin
          pop     = 1'b1;
          win_en  = 1'b1;
          win_req = head;
        end
      end
      default: state_nxt = ARB_NORMAL;
    endcase
    push = bus.mc_valid && !full && (bus.mc_reg != REG_X0) && !bypass;
  end

  // Register stage: the winning request lands on the write port one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ARB_NORMAL;
      starve_cnt     <= '0;
      bus.wb_en_out  <= 1'b0;
      bus.wb_reg_out <= '0;
      bus.wb_data    <= '0;
    end else begin
      state         <= state_nxt;
      starve_cnt    <= cnt_nxt;
      bus.wb_en_out <= win_en;
      if (win_en) begin
        bus.wb_reg_out <= win_req.rd;
        bus.wb_data    <= win_req.data;
      end
    end
  end

endmodule
